// File: rtl/fsk_mod_pkg.sv
// Shared FSK definitions used by both the transmitter (fsk_mod) and the receiver:
// state encodings, the SFD byte and the default timing/NCO parameters.
package fsk_mod_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SFD      = 2'd2,
    DATA     = 2'd3
  } txState_e;

  localparam logic [7:0] SFD_BYTE = 8'hD3;

  localparam int PHASE_W_DEF       = 8;
  localparam int F1_INC_DEF        = 16;
  localparam int F0_INC_DEF        = 32;
  localparam int SPB_DEF           = 16;
  localparam int PREAMBLE_BITS_DEF = 8;

  // Preamble alternates 1,0,1,0,... so even bit positions carry a 1.
  function automatic logic preambleBit(input logic bitCntLsb);
    return ~bitCntLsb;
  endfunction

endpackage

// File: rtl/fsk_mod_nco.sv
// Phase accumulator for the FSK transmitter; out_bit is the registered phase MSB,
// forced low while clr is asserted.
module fsk_mod_nco
  import fsk_mod_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PHASE_W-1:0] inc,
  output logic               out_bit
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               outBit_q;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + inc;
    end
  end

  // The output register lags the accumulator by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      outBit_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      outBit_q <= clr ? 1'b0 : phase_q[PHASE_W-1];
    end
  end

  assign out_bit = outBit_q;

endmodule

// File: rtl/fsk_mod.sv
// FSK transmitter: byte buffer, framing FSM (preamble / optional SFD / data) and NCO.
// Define FSK_MOD_SFD_EN to insert the 8-bit SFD field between preamble and data.
module fsk_mod
  import fsk_mod_pkg::*;
#(
  parameter int PHASE_W       = PHASE_W_DEF,
  parameter int F1_INC        = F1_INC_DEF,
  parameter int F0_INC        = F0_INC_DEF,
  parameter int SPB           = SPB_DEF,
  parameter int PREAMBLE_BITS = PREAMBLE_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       data_out,
  output logic       tx_busy,
  output logic       tx_bit
);

  localparam logic [4:0]         SAMPLE_LAST = 5'(SPB - 1);
  localparam logic [7:0]         PRE_LAST    = 8'(PREAMBLE_BITS - 1);
  localparam logic [PHASE_W-1:0] INC1        = PHASE_W'(F1_INC);
  localparam logic [PHASE_W-1:0] INC0        = PHASE_W'(F0_INC);

  txState_e   state_q, state_d;
  logic       bufFull_q, bufFull_d;
  logic [7:0] buf_q, buf_d;
  logic [7:0] shift_q, shift_d;
  logic [4:0] sampleCnt_q, sampleCnt_d;
  logic [7:0] bitCnt_q, bitCnt_d;
  logic       bitEnd;
  logic       load;
  logic       accept;
  logic       txBit;
  logic       ncoOut;

  assign bitEnd = en && (sampleCnt_q == SAMPLE_LAST);
  assign accept = data_in_valid && !bufFull_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving IDLE needs only an en tick; every other transition happens at a bit end.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && bufFull_q) begin
          if (PREAMBLE_BITS != 0) begin
            state_d = PREAMBLE;
          end else begin
`ifdef FSK_MOD_SFD_EN
            state_d = SFD;
`else
            state_d = DATA;
            load    = 1'b1;
`endif
          end
        end
      end
      PREAMBLE: begin
        if (bitEnd && (bitCnt_q == PRE_LAST)) begin
`ifdef FSK_MOD_SFD_EN
          state_d = SFD;
`else
          state_d = DATA;
          load    = 1'b1;
`endif
        end
      end
`ifdef FSK_MOD_SFD_EN
      SFD: begin
        if (bitEnd && (bitCnt_q == 8'd7)) begin
          state_d = DATA;
          load    = 1'b1;
        end
      end
`endif
      DATA: begin
        if (bitEnd && (bitCnt_q == 8'd7)) begin
          if (bufFull_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txBit = 1'b0;
    case (state_q)
      PREAMBLE: txBit = preambleBit(bitCnt_q[0]);
`ifdef FSK_MOD_SFD_EN
      SFD:      txBit = SFD_BYTE[bitCnt_q[2:0]];
`endif
      DATA:     txBit = shift_q[0];
      default:  txBit = 1'b0;
    endcase
  end

  // Bit counter restarts whenever a new field (or a new data byte) begins.
  always_comb begin
    sampleCnt_d = sampleCnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    if (state_q == IDLE) begin
      sampleCnt_d = '0;
      bitCnt_d    = '0;
    end else if (en) begin
      sampleCnt_d = bitEnd ? 5'd0 : sampleCnt_q + 5'd1;
      if (bitEnd) begin
        bitCnt_d = ((state_d != state_q) || load) ? 8'd0 : bitCnt_q + 8'd1;
        shift_d  = {1'b0, shift_q[7:1]};
      end
    end
    if (load) begin
      shift_d = buf_q;
    end
  end

  always_comb begin
    bufFull_d = bufFull_q;
    buf_d     = buf_q;
    if (accept) begin
      bufFull_d = 1'b1;
      buf_d     = data_in;
    end else if (load) begin
      bufFull_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bufFull_q   <= 1'b0;
      buf_q       <= '0;
      shift_q     <= '0;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
    end else begin
      bufFull_q   <= bufFull_d;
      buf_q       <= buf_d;
      shift_q     <= shift_d;
      sampleCnt_q <= sampleCnt_d;
      bitCnt_q    <= bitCnt_d;
    end
  end

  fsk_mod_nco #(
    .PHASE_W(PHASE_W)
  ) uNco (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (state_q == IDLE),
    .inc    (txBit ? INC1 : INC0),
    .out_bit(ncoOut)
  );

  assign data_in_ready = !bufFull_q;
  assign data_out      = ncoOut;
  assign tx_busy       = (state_q != IDLE);
  assign tx_bit        = txBit;

endmodule
